// File: rtl/lb_refill_pkg.sv
// Shared types and constants for the line-buffer refill port arbiter.
package lb_refill_pkg;

    localparam int LB_ADDR_W = 12;
    localparam int LB_DATA_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ADDR = 2'd2,
        DATA = 2'd3
    } state_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lb_refill_arbiter_rr_arbiter.sv
// Round-robin pick: first set request bit at or above ptr, wrapping.
module rr_arbiter
    import lb_refill_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand_s;

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        valid  = 1'b0;
        cand_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!valid && req[cand_s]) begin
                valid       = 1'b1;
                idx         = cand_s;
                gnt[cand_s] = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/lb_refill_arbiter.sv
// Shares the single LB refill port between NUM_REQ requesters with
// transaction-granular round-robin, a read-data watchdog and a spurious
// read-beat error flag.
module lb_refill_arbiter
    import lb_refill_pkg::*;
#(
    parameter  int NUM_REQ     = 2,
    parameter  int BURST_LEN   = 1,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int IDX_W       = idx_width(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ-1:0]                  we_i,
    output logic [NUM_REQ-1:0]                  gnt_o,
    input  logic [NUM_REQ-1:0][LB_ADDR_W-1:0]   addr_i,
    input  logic [NUM_REQ-1:0]                  addr_valid_i,
    output logic [NUM_REQ-1:0]                  addr_ready_o,
    input  logic [NUM_REQ-1:0]                  wvalid_i,
    input  logic [NUM_REQ-1:0][LB_DATA_W-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]                  rvalid_o,
    output logic [LB_DATA_W-1:0]                rdata_o,
    output logic                                lb_req,
    input  logic                                lb_gnt,
    output logic                                lb_we,
    output logic [LB_ADDR_W-1:0]                lb_addr,
    output logic                                lb_addr_valid,
    input  logic                                lb_addr_ready,
    output logic                                lb_wvalid,
    output logic [LB_DATA_W-1:0]                lb_wdata,
    input  logic                                lb_rvalid,
    input  logic [LB_DATA_W-1:0]                lb_rdata,
    output logic [IDX_W-1:0]                    owner_o,
    output logic                                busy_o,
    output logic                                err_timeout_o,
    output logic                                err_spurious_o
);

    localparam int CNT_W = idx_width(BURST_LEN);
    localparam int WD_W  = idx_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    state_t           state_r, state_s;
    logic [IDX_W-1:0] owner_r, owner_s;
    logic             we_r, we_s;
    logic [IDX_W-1:0] rr_ptr_r, rr_ptr_s;
    logic [CNT_W-1:0] beat_cnt_r, beat_cnt_s;
    logic [WD_W-1:0]  wdog_r, wdog_s;
    logic             err_timeout_r, err_timeout_s;
    logic             err_spurious_r, err_spurious_s;

    logic [NUM_REQ-1:0] arb_gnt_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic               arb_valid_s;
    logic               rd_phase_s;
    logic               beat_s;
    logic [IDX_W-1:0]   ptr_adv_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_i),
        .ptr   (rr_ptr_r),
        .gnt   (arb_gnt_s),
        .idx   (arb_idx_s),
        .valid (arb_valid_s)
    );

    // State and bookkeeping registers; async reset returns to idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            owner_r        <= '0;
            we_r           <= 1'b0;
            rr_ptr_r       <= '0;
            beat_cnt_r     <= '0;
            wdog_r         <= '0;
            err_timeout_r  <= 1'b0;
            err_spurious_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            owner_r        <= owner_s;
            we_r           <= we_s;
            rr_ptr_r       <= rr_ptr_s;
            beat_cnt_r     <= beat_cnt_s;
            wdog_r         <= wdog_s;
            err_timeout_r  <= err_timeout_s;
            err_spurious_r <= err_spurious_s;
        end
    end

    // Next-state logic: arbitration, handshakes, beat counting and watchdog.
    always_comb begin
        state_s        = state_r;
        owner_s        = owner_r;
        we_s           = we_r;
        rr_ptr_s       = rr_ptr_r;
        beat_cnt_s     = beat_cnt_r;
        wdog_s         = wdog_r;
        err_timeout_s  = err_timeout_r;
        err_spurious_s = err_spurious_r;

        rd_phase_s = (state_r == DATA) && !we_r;
        beat_s     = (state_r == DATA) && (we_r ? wvalid_i[owner_r] : lb_rvalid);
        ptr_adv_s  = (owner_r == LAST_IDX) ? '0 : owner_r + IDX_W'(1);

        // Read beats are only legal while a read owns the data phase.
        if (lb_rvalid && !rd_phase_s) begin
            err_spurious_s = 1'b1;
        end else begin
            err_spurious_s = err_spurious_r;
        end

        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    state_s = REQ;
                    owner_s = arb_idx_s;
                    we_s    = we_i[arb_idx_s];
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (lb_gnt) begin
                    state_s = ADDR;
                end else begin
                    state_s = REQ;
                end
            end
            ADDR: begin
                if (addr_valid_i[owner_r] && lb_addr_ready) begin
                    state_s    = DATA;
                    beat_cnt_s = '0;
                    wdog_s     = '0;
                end else begin
                    state_s = ADDR;
                end
            end
            DATA: begin
                if (beat_s) begin
                    wdog_s = '0;
                    if (beat_cnt_r == LAST_BEAT) begin
                        state_s    = IDLE;
                        beat_cnt_s = '0;
                        rr_ptr_s   = ptr_adv_s;
                    end else begin
                        beat_cnt_s = beat_cnt_r + CNT_W'(1);
                    end
                end else if (!we_r && (wdog_r == WD_LAST)) begin
                    // Read starved: abandon the transaction and move on.
                    err_timeout_s = 1'b1;
                    state_s       = IDLE;
                    rr_ptr_s      = ptr_adv_s;
                    wdog_s        = '0;
                    beat_cnt_s    = '0;
                end else if (!we_r) begin
                    wdog_s = wdog_r + WD_W'(1);
                end else begin
                    wdog_s = wdog_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output steering: only the owner's lanes are ever connected.
    always_comb begin
        gnt_o         = '0;
        addr_ready_o  = '0;
        rvalid_o      = '0;
        lb_req        = 1'b0;
        lb_we         = 1'b0;
        lb_addr       = '0;
        lb_addr_valid = 1'b0;
        lb_wvalid     = 1'b0;
        lb_wdata      = '0;
        case (state_r)
            IDLE: begin
                lb_req = 1'b0;
            end
            REQ: begin
                lb_req         = 1'b1;
                lb_we          = we_r;
                gnt_o[owner_r] = lb_gnt;
            end
            ADDR: begin
                lb_addr               = addr_i[owner_r];
                lb_addr_valid         = addr_valid_i[owner_r];
                addr_ready_o[owner_r] = lb_addr_ready;
            end
            DATA: begin
                if (we_r) begin
                    lb_wvalid = wvalid_i[owner_r];
                    lb_wdata  = wdata_i[owner_r];
                end else begin
                    rvalid_o[owner_r] = lb_rvalid;
                end
            end
            default: begin
                lb_req = 1'b0;
            end
        endcase
    end

    assign rdata_o        = lb_rdata;
    assign owner_o        = owner_r;
    assign busy_o         = (state_r != IDLE);
    assign err_timeout_o  = err_timeout_r;
    assign err_spurious_o = err_spurious_r;

endmodule

// File: tb/tb_lb_refill_arbiter.sv
// Randomized bench for lb_refill_arbiter: the bench plays both requesters and
// the LB side, and predicts owner order, routing and error flags from the
// protocol rules.
module tb_lb_refill_arbiter;
    import lb_refill_pkg::*;

    localparam int NR = 2;
    localparam int BL = 4;
    localparam int TO = 16;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic [NR-1:0]                  req_i, we_i, gnt_o;
    logic [NR-1:0][LB_ADDR_W-1:0]   addr_i;
    logic [NR-1:0]                  addr_valid_i, addr_ready_o, wvalid_i, rvalid_o;
    logic [NR-1:0][LB_DATA_W-1:0]   wdata_i;
    logic [LB_DATA_W-1:0]           rdata_o, lb_wdata, lb_rdata;
    logic                           lb_req, lb_gnt, lb_we, lb_addr_valid, lb_addr_ready;
    logic                           lb_wvalid, lb_rvalid, busy_o, err_timeout_o, err_spurious_o;
    logic [LB_ADDR_W-1:0]           lb_addr;
    logic [0:0]                     owner_o;

    always #5 clk = ~clk;

    lb_refill_arbiter #(.NUM_REQ(NR), .BURST_LEN(BL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .addr_valid_i(addr_valid_i), .addr_ready_o(addr_ready_o),
        .wvalid_i(wvalid_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .lb_req(lb_req), .lb_gnt(lb_gnt), .lb_we(lb_we), .lb_addr(lb_addr),
        .lb_addr_valid(lb_addr_valid), .lb_addr_ready(lb_addr_ready),
        .lb_wvalid(lb_wvalid), .lb_wdata(lb_wdata), .lb_rvalid(lb_rvalid),
        .lb_rdata(lb_rdata), .owner_o(owner_o), .busy_o(busy_o),
        .err_timeout_o(err_timeout_o), .err_spurious_o(err_spurious_o)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   ptr_m    = 0;
    logic spur_m   = 1'b0;
    logic tmo_m    = 1'b0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Round-robin rule: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int i = 0; i < NR; i++) if (r[(p + i) % NR]) return (p + i) % NR;
        return 0;
    endfunction

    task automatic idle_inputs();
        req_i = '0; we_i = '0; addr_i = '0; addr_valid_i = '0; wvalid_i = '0;
        wdata_i = '0; lb_gnt = 1'b0; lb_addr_ready = 1'b0; lb_rvalid = 1'b0; lb_rdata = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        lb_rdata = rand256();
        #1;
        check_eq({tag, "_busy"}, busy_o, 1'b0);
        check_eq({tag, "_gnt"}, gnt_o, 2'b00);
        check_eq({tag, "_lbreq"}, lb_req, 1'b0);
        check_eq({tag, "_owner"}, owner_o, 1'b0);
        check_eq({tag, "_rvalid"}, rvalid_o, 2'b00);
        check_eq({tag, "_lbwvalid"}, lb_wvalid, 1'b0);
        check_eq({tag, "_lbaddrv"}, lb_addr_valid, 1'b0);
        check_eq({tag, "_errto"}, err_timeout_o, 1'b0);
        check_eq({tag, "_errsp"}, err_spurious_o, 1'b0);
        check_eq({tag, "_rdata"}, rdata_o, lb_rdata);
    endtask

    // mode 0: normal, 1: read with no data (watchdog), 2: reset after first beat.
    // Entered and left in an IDLE cycle, just after a rising edge.
    task automatic run_txn(input logic [NR-1:0] reqs, input int mode);
        int             own;
        logic [NR-1:0]  wev, oh;
        logic           is_wr;
        logic [255:0]   d;
        wev = NR'($urandom_range(0, 3));
        if (mode != 0) wev = '0;
        own   = pick(reqs, ptr_m);
        oh    = NR'(1 << own);
        is_wr = wev[own];
        req_i = reqs; we_i = wev; addr_valid_i = '1;
        addr_i[0] = 12'($urandom_range(0, 4095));
        addr_i[1] = 12'($urandom_range(0, 4095));
        if ($urandom_range(0, 3) == 0) begin
            lb_rvalid = 1'b1;
            spur_m    = 1'b1;
        end
        #1;
        check_eq("idle_busy", busy_o, 1'b0);
        check_eq("idle_rvalid", rvalid_o, 2'b00);
        step();
        lb_rvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            #1;
            check_eq("req_lbreq", lb_req, 1'b1);
            check_eq("req_lbwe", lb_we, is_wr);
            check_eq("req_gnt_low", gnt_o, 2'b00);
            check_eq("req_owner", owner_o, own);
            check_eq("req_errsp", err_spurious_o, spur_m);
            step();
        end
        lb_gnt = 1'b1;
        #1;
        check_eq("req_gnt", gnt_o, oh);
        step();
        lb_gnt = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            #1;
            check_eq("addr_val", lb_addr, addr_i[own]);
            check_eq("addr_valid", lb_addr_valid, 1'b1);
            check_eq("addr_rdy_low", addr_ready_o, 2'b00);
            step();
        end
        lb_addr_ready = 1'b1;
        #1;
        check_eq("addr_rdy", addr_ready_o, oh);
        check_eq("addr_val_hs", lb_addr, addr_i[own]);
        step();
        lb_addr_ready = 1'b0;
        if (mode == 1) begin
            for (int k = 0; k < TO; k++) begin
                #1;
                check_eq("wd_busy", busy_o, 1'b1);
                check_eq("wd_errto", err_timeout_o, tmo_m);
                step();
            end
            tmo_m = 1'b1;
            ptr_m = (own + 1) % NR;
            #1;
            check_eq("wd_idle", busy_o, 1'b0);
            check_eq("wd_errto_set", err_timeout_o, 1'b1);
            return;
        end
        for (int b = 0; b < BL; b++) begin
            repeat ($urandom_range(0, 2)) begin
                wvalid_i = '0;
                if (is_wr && $urandom_range(0, 3) == 0) begin
                    lb_rvalid = 1'b1;
                    spur_m    = 1'b1;
                end
                #1;
                check_eq("gap_rvalid", rvalid_o, 2'b00);
                check_eq("gap_wvalid", lb_wvalid, 1'b0);
                step();
                lb_rvalid = 1'b0;
            end
            if (mode == 2 && b == 1) begin
                rst_n = 1'b0;
                check_reset_outputs("rst_mid");
                idle_inputs();
                @(negedge clk);
                rst_n = 1'b1;
                step();
                ptr_m = 0; spur_m = 1'b0; tmo_m = 1'b0;
                return;
            end
            if (is_wr) begin
                wvalid_i   = '1;
                wdata_i[0] = rand256();
                wdata_i[1] = rand256();
                d          = wdata_i[own];
                #1;
                check_eq("wr_valid", lb_wvalid, 1'b1);
                check_eq("wr_data", lb_wdata, d);
                check_eq("wr_no_rvalid", rvalid_o, 2'b00);
            end else begin
                lb_rvalid = 1'b1;
                lb_rdata  = rand256();
                d         = lb_rdata;
                #1;
                check_eq("rd_valid", rvalid_o, oh);
                check_eq("rd_data", rdata_o, d);
            end
            step();
            wvalid_i  = '0;
            lb_rvalid = 1'b0;
        end
        ptr_m = (own + 1) % NR;
        #1;
        check_eq("end_idle", busy_o, 1'b0);
        check_eq("end_errsp", err_spurious_o, spur_m);
        check_eq("end_owner", owner_o, own);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        // Continuous contention: owners must alternate.
        for (int i = 0; i < 4; i++) run_txn(2'b11, 0);
        for (int i = 0; i < 20; i++) run_txn(NR'($urandom_range(1, 3)), 0);
        // Put the pointer on requester 1, starve its read, then 0 is next.
        run_txn(2'b01, 0);
        run_txn(2'b11, 1);
        run_txn(2'b11, 0);
        // Reset mid-burst, then a lone request from requester 1.
        run_txn(2'b11, 2);
        run_txn(2'b10, 0);
        for (int i = 0; i < 6; i++) run_txn(NR'($urandom_range(1, 3)), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
